shift_rot_pipe: RTL
===================

Name: shift_rot_pipe

Overview:
- Parametrised, pipelined shift/rotate unit; successor to the fixed 32-bit clocked right-shift/rotate block.
- Adds a run-time operation select (logical left/right, arithmetic right, rotate left/right) and a configurable width.
- Splits the log-shifter across STAGES register stages, with valid/ready handshakes on both sides.
- Sits in the execute path of the 64-bit core, between operand fetch and writeback.

Parameters:
- WIDTH, 64, data width in bits; must be a power of two, 8 to 128.
- STAGES, 2, pipeline register stages; legal range 1 to log2(WIDTH).
- SHW, log2(WIDTH), derived localparam: shift-amount width; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  unit accepts an operand this cycle
- in_data  input  WIDTH  operand
- in_amt  input  SHW  shift/rotate amount, 0 to WIDTH-1
- in_op  input  3  operation: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101-111 pass-through
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result

Behaviour:
- Reset (rst high at a clk edge):
  - All stage valid bits clear; out_valid=0, out_data=0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Any in-flight operations are discarded.
- Shifter structure:
  - Log-shifter with SHW levels; level k shifts by 2^k when in_amt[k] is set.
  - Levels are distributed across stages: ceil(SHW/STAGES) levels per stage, earlier stages take the lower amount bits.
  - Each stage carries forward data, the remaining amount bits, op and valid.
- Operation semantics:
  - SRL fills with zeros; SLL fills with zeros.
  - SRA fills with in_data[WIDTH-1].
  - ROR/ROL wrap bits end-around.
  - in_amt=0 gives out_data=in_data for every op.
  - Pass-through ops give out_data=in_data regardless of in_amt.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, a combinational function of registered out_valid and out_ready.
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads in_valid, so a bubble enters when in_valid=0.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
- Latency:
  - Exactly STAGES cycles from the input transfer to out_valid, with no backpressure.
  - Throughput is 1 result per cycle while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold stable until the transfer.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are both legal; there is no loss and no duplication.
  - rst overrides all handshakes.
- Ordering: results emerge in input order.

Optional Feature:
- Macro: SHIFT_FLAGS_EN
- When defined, two extra output ports are added, each registered alongside out_data and following the same valid/hold rules:
  - out_zero, 1 bit: high when out_data == 0.
  - out_carry, 1 bit: last bit shifted out.
    - SRL/SRA/ROR: in_data[in_amt-1].
    - SLL/ROL: in_data[WIDTH-in_amt].
    - Forced to 0 when in_amt=0 or for pass-through ops.
  - Both flags reset to 0.
- When undefined, neither port exists and no flag logic is synthesised.

Test Plan:
- Rotate right, WIDTH=32, STAGES=2: in_data=0xF0000001, in_amt=5, op=ROR, out_ready=1 -> out_data=0x0F800000 exactly 2 cycles after the transfer; with flags, out_carry=0, out_zero=0.
- Arithmetic and logical right shift, WIDTH=32: in_data=0x80000000, in_amt=4 -> SRA gives 0xF8000000, SRL gives 0x08000000; left shift of 0x00000001 by 31 gives 0x80000000, carry=0.
- Boundary amounts, WIDTH=64: in_amt=0 for all five ops gives in_data unchanged; ROL of 0x8000000000000001 by 63 gives 0xC000000000000000.
- Backpressure: stream 4 operands back-to-back, hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, out_data stable, all 4 results delivered in order with none lost or duplicated.
- Reset mid-operation: rst pulsed for 1 cycle while 2 operations are in flight -> out_valid=0 and out_data=0 the next cycle, no stale result ever appears, and a new operand completes normally afterwards.
- STAGES sweep: for STAGES=1 and STAGES=log2(WIDTH), 1000 random operands are compared against a reference model, and latency equals STAGES.

Source files
------------

// File: rtl/shift_rot_pipe.sv
// rtl/shift_rot_pipe.sv - pipelined shift/rotate unit with a valid/ready stall, log-shifter levels split across STAGES
// Optional SHIFT_FLAGS_EN adds registered out_zero/out_carry flags.
module shift_rot_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int LPS = (SHW + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SRL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    logic [WIDTH-1:0] data_q [STAGES];
    logic [SHW-1:0]   amt_q  [STAGES];
    logic [2:0]       op_q   [STAGES];
    logic             vld_q  [STAGES];

    logic [WIDTH-1:0] sd  [STAGES];
    logic [SHW-1:0]   sa  [STAGES];
    logic [2:0]       so  [STAGES];
    logic [WIDTH-1:0] nxt [STAGES];

    logic adv;

    // The whole pipe moves as one: any stall at the output freezes every stage.
    assign adv       = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    function automatic logic [WIDTH-1:0] level(input logic [WIDTH-1:0] d,
                                               input logic [2:0] op,
                                               input int sh);
        case (op)
            OP_SRL:  level = d >> sh;
            OP_SLL:  level = d << sh;
            OP_SRA:  level = $signed(d) >>> sh;
            OP_ROR:  level = (d >> sh) | (d << (WIDTH - sh));
            OP_ROL:  level = (d << sh) | (d >> (WIDTH - sh));
            default: level = d;
        endcase
    endfunction

    always_comb begin
        sd[0] = in_data;
        sa[0] = in_amt;
        so[0] = in_op;
        for (int s = 1; s < STAGES; s++) begin
            sd[s] = data_q[s-1];
            sa[s] = amt_q[s-1];
            so[s] = op_q[s-1];
        end
        // Stage s owns amount bits [s*LPS, (s+1)*LPS); SRA keeps its sign bit at the MSB throughout.
        for (int s = 0; s < STAGES; s++) begin
            nxt[s] = sd[s];
            for (int k = 0; k < SHW; k++) begin
                if ((k / LPS) == s && sa[s][k]) begin
                    nxt[s] = level(nxt[s], so[s], 1 << k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                op_q[s]   <= '0;
                vld_q[s]  <= 1'b0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= nxt[s];
                amt_q[s]  <= sa[s];
                op_q[s]   <= so[s];
            end
        end
    end

`ifdef SHIFT_FLAGS_EN
    logic             cy_q [STAGES];
    logic             cy_in;
    logic [SHW-1:0]   amt_m1;
    logic [SHW-1:0]   amt_neg;
    logic             zero_q;

    assign amt_m1  = in_amt - SHW'(1);
    assign amt_neg = ~in_amt + SHW'(1);

    // The last bit shifted out is known from the operand alone, so it is computed up front and carried.
    always_comb begin
        cy_in = 1'b0;
        if (in_amt != '0) begin
            case (in_op)
                OP_SRL, OP_SRA, OP_ROR: cy_in = in_data[amt_m1];
                OP_SLL, OP_ROL:         cy_in = in_data[amt_neg];
                default:                cy_in = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                cy_q[s] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (adv) begin
            cy_q[0] <= cy_in;
            for (int s = 1; s < STAGES; s++) begin
                cy_q[s] <= cy_q[s-1];
            end
            zero_q <= (nxt[STAGES-1] == '0);
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = cy_q[STAGES-1];
`endif

endmodule
